// File: rtl/fc_scheduler.sv
// fc_scheduler: time-multiplexes NUM_OUT neurons onto one shared datapath for each input vector and collects the results.
// Latency: valid_out pulses NUM_OUT+PIPE_DEPTH edges after the accept edge; back-to-back rate is one vector per NUM_OUT+PIPE_DEPTH+1 cycles.
// Backpressure: ready_in is high only in IDLE, and valid_in is ignored while busy. The datapath has no stall, because its latency is fixed.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   valid_in/ready_in    input vector handshake; i_data is the vector, with word 0 in the LSBs
//   dp_valid/dp_sel      issue strobe and weight/bank index to the shared datapath
//   dp_data              latched input vector, held from accept until the return to IDLE
//   dp_result            datapath output, valid PIPE_DEPTH cycles after its issue
//   o_data/valid_out     collected results (neuron k in word k) and a one-cycle completion pulse
//   busy                 high whenever the FSM is not in IDLE
// Optional feature: define FC_SCHEDULER_RELU_EN to clamp captured words that have the sign bit set to zero.
module fc_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 16,
  parameter int NUM_OUT    = 2,
  parameter int PIPE_DEPTH = 5,
  localparam int SEL_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH*NUM_IN-1:0] i_data,
  output logic                         ready_in,
  output logic                         dp_valid,
  output logic [SEL_W-1:0]             dp_sel,
  output logic [DATA_WIDTH*NUM_IN-1:0] dp_data,
  input  logic [DATA_WIDTH-1:0]        dp_result,
  output logic [DATA_WIDTH*NUM_OUT-1:0] o_data,
  output logic                         valid_out,
  output logic                         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OUT - 1);

  state_t                              state_q, state_d;
  logic [SEL_W-1:0]                    cnt_q, cnt_d;
  logic                                vout_q, vout_d;
  logic [DATA_WIDTH*NUM_IN-1:0]        dp_data_q;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0]  o_data_q;
  // Issue tracking: stage 0 is loaded at the edge that closes an issue cycle.
  // The last stage therefore marks the edge on which that issue's result is on dp_result.
  logic [PIPE_DEPTH-1:0]               line_vld_q;
  logic [PIPE_DEPTH-1:0][SEL_W-1:0]    line_sel_q;

  logic                  accept;
  logic                  cap_vld;
  logic                  cap_last;
  logic [SEL_W-1:0]      cap_sel;
  logic [DATA_WIDTH-1:0] cap_word;

  // ready_in is gated by rst so that it reads low for the whole reset pulse.
  assign ready_in  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign dp_valid  = (state_q == ISSUE);
  assign dp_sel    = dp_valid ? cnt_q : '0;
  assign dp_data   = dp_data_q;
  assign o_data    = o_data_q;
  assign valid_out = vout_q;

  assign accept   = valid_in && ready_in;
  assign cap_vld  = line_vld_q[PIPE_DEPTH-1];
  assign cap_sel  = line_sel_q[PIPE_DEPTH-1];
  assign cap_last = cap_vld && (cap_sel == LAST_SEL);

  always_comb begin
    cap_word = dp_result;
`ifdef FC_SCHEDULER_RELU_EN
    // ReLU on the raw IEEE word: any negative value, including -0.0, becomes +0.0.
    if (dp_result[DATA_WIDTH-1]) cap_word = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (cnt_q == LAST_SEL) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      DRAIN: begin
        // The last index always comes out in DRAIN, because PIPE_DEPTH >= 1.
        if (cap_last) begin
          state_d = IDLE;
          vout_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vout_q  <= vout_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_data_q  <= '0;
      o_data_q   <= '0;
      line_vld_q <= '0;
      line_sel_q <= '0;
    end else begin
      if (accept) dp_data_q <= i_data;
      line_vld_q[0] <= dp_valid;
      line_sel_q[0] <= dp_sel;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        line_vld_q[i] <= line_vld_q[i-1];
        line_sel_q[i] <= line_sel_q[i-1];
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        if (cap_vld && (cap_sel == SEL_W'(k))) o_data_q[k] <= cap_word;
      end
    end
  end

endmodule

// File: tb/tb_fc_scheduler.sv
// Bench for fc_scheduler: default build (2 neurons, depth 5) plus a 1-neuron, depth-1 instance.
// Expected values come from cycle offsets relative to the accept edge and from per-transaction result tables.
module tb_fc_scheduler;
  localparam int DW = 32;
  localparam int NI = 16;
  localparam int N  = 2;
  localparam int P  = 5;
  localparam int VW = DW * NI;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, valid_in, ready_in, dp_valid, valid_out, busy;
  logic [VW-1:0] i_data, dp_data;
  logic [0:0]    dp_sel;
  logic [DW-1:0] dp_result;
  logic [DW*N-1:0] o_data;

  logic          valid_in1, ready_in1, dp_valid1, valid_out1, busy1;
  logic [VW-1:0] i_data1, dp_data1;
  logic [0:0]    dp_sel1;
  logic [DW-1:0] dp_result1, o_data1;

  fc_scheduler #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(N), .PIPE_DEPTH(P)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .i_data(i_data), .ready_in(ready_in),
    .dp_valid(dp_valid), .dp_sel(dp_sel), .dp_data(dp_data), .dp_result(dp_result),
    .o_data(o_data), .valid_out(valid_out), .busy(busy));

  fc_scheduler #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(1), .PIPE_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in1), .i_data(i_data1), .ready_in(ready_in1),
    .dp_valid(dp_valid1), .dp_sel(dp_sel1), .dp_data(dp_data1), .dp_result(dp_result1),
    .o_data(o_data1), .valid_out(valid_out1), .busy(busy1));

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] res_tbl [N];
  logic [DW-1:0] exp_slot [N];
  logic [DW-1:0] res1;

  // Fixed-latency datapath model. Each cycle's issue is remembered, and the
  // table result is presented P cycles later. At all other times the output is random junk.
  logic hv [0:P];
  logic hs [0:P];
  logic h1;
  initial begin
    for (int j = 0; j <= P; j++) begin hv[j] = 1'b0; hs[j] = 1'b0; end
    h1 = 1'b0;
    dp_result = '0;
    dp_result1 = '0;
    res1 = '0;
  end
  always @(negedge clk) begin
    for (int j = P; j > 0; j--) begin hv[j] = hv[j-1]; hs[j] = hs[j-1]; end
    hv[0] = dp_valid;
    hs[0] = dp_sel[0];
    dp_result = hv[P] ? res_tbl[hs[P]] : $urandom;
  end
  always @(negedge clk) begin
    dp_result1 = h1 ? res1 : $urandom;
    h1 = dp_valid1;
  end

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] w);
`ifdef FC_SCHEDULER_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NI; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one vector and checks every cycle up to and including the valid_out cycle.
  // In cycle j after the accept edge, slot k is expected to show its new value once j >= k+1+P.
  task automatic txn(input logic [VW-1:0] vec, input bit hold);
    int waited;
    logic [DW-1:0]   new_slot [N];
    logic [DW*N-1:0] oe;
    for (int k = 0; k < N; k++) new_slot[k] = relu_ref(res_tbl[k]);
    i_data = vec;
    valid_in = 1'b1;
    waited = 0;
    while (!ready_in && waited < 50) begin tick(); waited++; end
    chk("accept_wait", waited, 0);
    tick();
    if (!hold) valid_in = 1'b0;
    for (int j = 0; j <= N + P; j++) begin
      chk("dp_valid", dp_valid, (j < N));
      chk("dp_sel", dp_sel, (j < N) ? j : 0);
      chk("busy", busy, (j < N + P));
      chk("ready_in", ready_in, (j == N + P));
      chk("valid_out", valid_out, (j == N + P));
      chk("dp_data", dp_data, vec);
      for (int k = 0; k < N; k++) oe[k*DW +: DW] = (j >= k + 1 + P) ? new_slot[k] : exp_slot[k];
      chk("o_data", o_data, oe);
      if (j < N + P) begin
        tick();
        i_data = rand_vec();
      end
    end
    for (int k = 0; k < N; k++) exp_slot[k] = new_slot[k];
  endtask

  initial begin
    logic [VW-1:0] v;
    rst = 1'b1; valid_in = 1'b0; i_data = '0; valid_in1 = 1'b0; i_data1 = '0;
    for (int k = 0; k < N; k++) begin res_tbl[k] = '0; exp_slot[k] = '0; end
    repeat (3) tick();
    chk("rst_ready", ready_in, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_dp_sel", dp_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_dp_data", dp_data, 0);
    chk("rst_o_data", o_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", ready_in, 1);
    chk("post_rst_ready1", ready_in1, 1);

    // Single vector with random results.
    for (int k = 0; k < N; k++) res_tbl[k] = $urandom;
    txn(rand_vec(), 1'b0);
    repeat (2) tick();

    // Negative results: -1.0 in slot 0 and -0.0 in slot 1.
    res_tbl[0] = 32'hBF80_0000;
    res_tbl[1] = 32'h8000_0000;
    txn(rand_vec(), 1'b0);
    tick();

    // valid_in held high: each vector is accepted on the edge right after valid_out.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < N; k++) res_tbl[k] = $urandom;
      txn(rand_vec(), (t < 3));
    end
    repeat (2) tick();

    // Reset three cycles after the accept edge: in-flight results must never land.
    for (int k = 0; k < N; k++) res_tbl[k] = $urandom | 32'h1;
    v = rand_vec();
    i_data = v;
    valid_in = 1'b1;
    chk("mid_ready", ready_in, 1);
    tick();
    valid_in = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dp_valid", dp_valid, 0);
    chk("mid_rst_dp_data", dp_data, 0);
    chk("mid_rst_o_data", o_data, 0);
    for (int k = 0; k < N; k++) exp_slot[k] = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_ready", ready_in, 1);
    for (int j = 0; j < N + P + 3; j++) begin
      tick();
      chk("mid_valid_out", valid_out, 0);
      chk("mid_o_data", o_data, 0);
      chk("mid_busy", busy, 0);
    end

    // Single-neuron, depth-1 build: valid_out appears two edges after accept.
    res1 = $urandom;
    v = rand_vec();
    i_data1 = v;
    valid_in1 = 1'b1;
    chk("n1_ready", ready_in1, 1);
    tick();
    valid_in1 = 1'b0;
    for (int j = 0; j <= 2; j++) begin
      chk("n1_dp_valid", dp_valid1, (j == 0));
      chk("n1_dp_sel", dp_sel1, 0);
      chk("n1_busy", busy1, (j < 2));
      chk("n1_valid_out", valid_out1, (j == 2));
      chk("n1_dp_data", dp_data1, v);
      chk("n1_o_data", o_data1, (j == 2) ? relu_ref(res1) : 32'h0);
      if (j < 2) begin
        tick();
        i_data1 = rand_vec();
      end
    end
    tick();
    chk("n1_valid_out_pulse", valid_out1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
